usrt_tx_fifo: RTL and testbench

Parametrised next-generation USRT transmit path. It buffers words written from the AMBA side in a DEPTH-entry FIFO, then frames and serializes them onto Rx. Each bit period is generated by an internal divider. Data width, parity mode, stop-bit count and divider are configurable. It replaces the fixed 8-bit serializer/baud_gen pair and adds a valid/ready handshake, back-to-back frames and overrun reporting.

---
 rtl/usrt_tx_fifo_if.sv | 12 +
 rtl/usrt_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_usrt_tx_fifo.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usrt_tx_fifo_if.sv
// Write-side valid/ready handshake between the AMBA bridge and the USRT transmit FIFO.
// The bridge drives valid/data as master; the transmitter returns ready as slave.
interface usrt_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/usrt_tx_fifo.sv
// USRT transmit path: DEPTH-entry write FIFO feeding a framing serializer
// (start 1, LSB-first data, optional parity, stop 0s) clocked by an internal bit divider.
module usrt_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int DIV       = 80,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                       pClk,
  input  logic                       pReset,
  usrt_tx_fifo_if.slave              wr,
  input  logic                       tx_en,
  input  logic                       ovr_clr,
  output logic                       Rx,
  output logic                       uClk,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DIV);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push, pop, shift_en, bit_end, start_ok;
  logic [DATA_W-1:0] head;

  // Storage has no reset: only entries between the pointers are ever observed.
  always_ff @(posedge pClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    start_ok = (count_q != '0) && tx_en;
    bit_end  = (state_q != ST_IDLE) && (div_q == DW'(DIV - 1));
    push     = wr.wr_valid && wr_ready_q;

    state_d  = state_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    pop      = 1'b0;
    shift_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next frame so back-to-back words leave no idle gap.
            if (start_ok) begin
              state_d = ST_START;
              pop     = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE || div_q == DW'(DIV - 1)) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    wr_ready_d = (count_d != CW'(DEPTH));

    // A rejected write sets the flag; the set beats a simultaneous clear.
    if (wr.wr_valid && !wr_ready_q) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge pClk) begin
    if (!pReset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      ovr_q      <= ovr_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        shift_q  <= head;
        par_q    <= (^head) ^ (PARITY == 2);
      end else if (shift_en) begin
        shift_q  <= shift_q >> 1;
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_START:  Rx = 1'b1;
      ST_DATA:   Rx = shift_q[0];
      ST_PARITY: Rx = par_q;
      default:   Rx = 1'b0;
    endcase
  end

  assign uClk        = bit_end;
  assign busy        = (state_q != ST_IDLE);
  assign count       = count_q;
  assign ovr         = ovr_q;
  assign wr.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Scoreboard bench: four transmitters with different parity/stop settings; words pushed
// are queued as expected frames and per-instance line monitors decode Rx and compare.
module tb_usrt_tx_fifo;

  localparam int NI  = 4;
  localparam int DIV = 4;
  localparam int DW  = 8;
  // Two bits per instance, instance 0 in the low bits.
  localparam logic [7:0] PAR_V = 8'b00_01_10_01;
  localparam logic [7:0] STP_V = 8'b01_10_01_01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        rst_n, tx_en, ovr_clr, wv;
  logic [NI-1:0][7:0]   wd;
  logic [NI-1:0]        rx, uclk, busy, wrdy, ovr;
  logic [NI-1:0][2:0]   cnt;

  logic [7:0] sb_q [NI][$];
  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int P  = int'(PAR_V[2*gi +: 2]);
    localparam int S  = int'(STP_V[2*gi +: 2]);
    localparam int NB = 1 + DW + ((P != 0) ? 1 : 0) + S;

    usrt_tx_fifo_if #(.DATA_W(DW)) wr_if ();

    assign wr_if.wr_valid = wv[gi];
    assign wr_if.wr_data  = wd[gi];
    assign wrdy[gi]       = wr_if.wr_ready;

    usrt_tx_fifo #(
      .DATA_W(DW), .DEPTH(4), .DIV(DIV), .PARITY(P), .STOP_BITS(S)
    ) u_dut (
      .pClk   (clk),
      .pReset (rst_n[gi]),
      .wr     (wr_if),
      .tx_en  (tx_en[gi]),
      .ovr_clr(ovr_clr[gi]),
      .Rx     (rx[gi]),
      .uClk   (uclk[gi]),
      .busy   (busy[gi]),
      .count  (cnt[gi]),
      .ovr    (ovr[gi])
    );

    int pos = -1;
    int bad, ubad, bbad;
    logic [7:0]  expw, gotw;
    logic [15:0] fb;

    // Line monitor: a rising Rx while idle marks a start bit; the whole frame is
    // then compared cycle by cycle against the bits built from the expected word.
    always @(negedge clk) begin
      if (!rst_n[gi]) begin
        pos = -1;
      end else begin
        if (pos < 0 && rx[gi]) begin
          if (sb_q[gi].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame[%0d] got=start_bit exp=idle_line", gi);
            expw = 8'h00;
          end else begin
            expw = sb_q[gi].pop_front();
          end
          fb = '0;
          fb[0] = 1'b1;
          for (int b = 0; b < DW; b++) fb[1+b] = expw[b];
          if (P != 0) fb[1+DW] = (^expw) ^ (P == 2);
          pos = 0; bad = 0; ubad = 0; bbad = 0; gotw = '0;
        end
        if (pos >= 0) begin
          if (rx[gi] !== fb[pos/DIV]) bad++;
          if (uclk[gi] !== ((pos % DIV) == DIV - 1)) ubad++;
          if (busy[gi] !== 1'b1) bbad++;
          if ((pos % DIV) == DIV/2 && pos/DIV >= 1 && pos/DIV <= DW) gotw[pos/DIV-1] = rx[gi];
          pos++;
          if (pos == NB*DIV) begin
            checks += 3;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame[%0d] got=%02h exp=%02h bad_cycles=%0d", gi, gotw, expw, bad);
            end
            if (ubad != 0) begin
              errors++;
              $display("FAIL uclk[%0d] frame=%02h got=%0d_misplaced_cycles exp=0", gi, expw, ubad);
            end
            if (bbad != 0) begin
              errors++;
              $display("FAIL busy_in_frame[%0d] frame=%02h got=%0d_low_cycles exp=0", gi, expw, bbad);
            end
            $display("inst %0d frame %02h decoded %02h", gi, expw, gotw);
            pos = -1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_now(input int i, input logic [7:0] d, input bit accept);
    wv[i] = 1'b1;
    wd[i] = d;
    if (accept) sb_q[i].push_back(d);
    tick();
    wv[i] = 1'b0;
    wd[i] = ~d;
  endtask

  task automatic wait_busy(input int i, input logic level, input string name);
    int w = 0;
    while (busy[i] !== level && w < 400) begin
      tick();
      w++;
    end
    chk(name, busy[i], level);
  endtask

  task automatic measure_busy(input int i, input int exp_len, input string name);
    int n = 0;
    int w = 0;
    while (!busy[i] && w < 20) begin
      tick();
      w++;
    end
    if (!busy[i]) begin
      chk({name, "_rise"}, busy[i], 1);
    end else begin
      n = 1;
      while (n < 5000) begin
        tick();
        if (!busy[i]) break;
        n++;
      end
      chk(name, n, exp_len);
    end
  endtask

  initial begin
    int n;
    rst_n = '0; tx_en = '0; ovr_clr = '0; wv = '0; wd = '0;
    repeat (3) tick();
    rst_n = '1;
    tick();

    for (int i = 0; i < NI; i++) begin
      chk("reset_rx", rx[i], 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_count", cnt[i], 0);
      chk("reset_wr_ready", wrdy[i], 1);
      chk("reset_ovr", ovr[i], 0);
      chk("reset_uclk", uclk[i], 0);
    end

    // Single frames: even parity, odd parity, no parity.
    tx_en[0] = 1'b1;
    push_now(0, 8'hA5, 1'b1);
    measure_busy(0, 44, "len_even");
    tx_en[1] = 1'b1;
    push_now(1, 8'hA5, 1'b1);
    measure_busy(1, 44, "len_odd");
    tx_en[3] = 1'b1;
    push_now(3, 8'hA5, 1'b1);
    measure_busy(3, 40, "len_nopar");

    // Fill while disabled, overrun on the fifth word, then drain back-to-back.
    tx_en[0] = 1'b0;
    push_now(0, 8'h01, 1'b1);
    push_now(0, 8'h02, 1'b1);
    push_now(0, 8'h03, 1'b1);
    push_now(0, 8'h04, 1'b1);
    chk("full_count", cnt[0], 4);
    chk("full_wr_ready", wrdy[0], 0);
    chk("pre_ovr", ovr[0], 0);
    push_now(0, 8'h05, 1'b0);
    chk("ovr_set", ovr[0], 1);
    chk("ovr_count", cnt[0], 4);
    ovr_clr[0] = 1'b1;
    tick();
    ovr_clr[0] = 1'b0;
    chk("ovr_clr", ovr[0], 0);
    tx_en[0] = 1'b1;
    measure_busy(0, 176, "len_burst4");
    chk("burst_count", cnt[0], 0);

    // Two stop bits; disable during the second frame's data bits.
    tx_en[2] = 1'b0;
    push_now(2, 8'h11, 1'b1);
    push_now(2, 8'h22, 1'b1);
    push_now(2, 8'h33, 1'b1);
    tx_en[2] = 1'b1;
    wait_busy(2, 1'b1, "stop2_rise");
    n = 1;
    while (busy[2] && n < 1000) begin
      if (n == 60) tx_en[2] = 1'b0;
      tick();
      if (busy[2]) n++;
    end
    chk("len_stop2_pair", n, 96);
    chk("stop2_queued", cnt[2], 1);
    tx_en[2] = 1'b1;
    measure_busy(2, 48, "len_stop2");

    // Reset in the middle of a data bit abandons the frame and empties the FIFO.
    push_now(0, 8'h5A, 1'b1);
    push_now(0, 8'h66, 1'b1);
    repeat (10) tick();
    chk("pre_reset_busy", busy[0], 1);
    chk("pre_reset_count", cnt[0], 1);
    rst_n[0] = 1'b0;
    tick();
    chk("midrst_rx", rx[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_count", cnt[0], 0);
    chk("midrst_wr_ready", wrdy[0], 1);
    sb_q[0].delete();
    rst_n[0] = 1'b1;
    tick();
    push_now(0, 8'h3C, 1'b1);
    measure_busy(0, 44, "len_after_rst");

    // Push on exactly the edge that pops the next word at the end of a frame.
    push_now(3, 8'h81, 1'b1);
    wait_busy(3, 1'b1, "pp_rise");
    push_now(3, 8'h42, 1'b1);
    repeat (38) tick();
    chk("pp_count_before", cnt[3], 1);
    push_now(3, 8'h24, 1'b1);
    chk("pp_count_after", cnt[3], 1);
    chk("pp_busy", busy[3], 1);
    wait_busy(3, 1'b0, "pp_drain");

    repeat (4) tick();
    for (int i = 0; i < NI; i++) begin
      chk("sb_leftover", sb_q[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
